// File: rtl/ej32_pkg.sv
// Shared types for the EJ32 fetch path: FSM states, bus word type and big-endian byte-lane helper.
package ej32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_st_t;

  typedef logic [31:0] word_t;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  // Byte 0 of a word sits in the most significant lane.
  function automatic logic [BYTE_W-1:0] byte_lane(input word_t w, input logic [1:0] off);
    return w[(LANES - 1 - int'(off)) * BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/ej32_wq.sv
// Word queue for the fetch unit: power-of-two FIFO with clear, count and a combinational head.
module ej32_wq
  import ej32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  word_t                      push_data,
  input  logic                       pop,
  output word_t                      head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  word_t           mem [DEPTH];
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW:0]     cnt_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt_reg == DEPTH_CNT);
  assign empty   = (cnt_reg == '0);
  assign count   = cnt_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      cnt_reg <= cnt_reg + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/ej32_fetch.sv
// EJ32 instruction fetch: word reads into a prefetch queue, one byte per cycle to the decoder.
// Define EJ32_FETCH_BYPASS_EN to forward an acked word straight to data when the queue is empty.
module ej32_fetch
  import ej32_pkg::*;
#(
  parameter int unsigned COLD  = 'h0,
  parameter int          ASZ   = 17,
  parameter int          DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           mem_req,
  output logic [ASZ-3:0] mem_addr,
  input  logic           mem_ack,
  input  logic [31:0]    mem_rdata,
  input  logic           jmp,
  input  logic [ASZ-1:0] jmp_addr,
  input  logic           take,
  output logic [7:0]     data,
  output logic           data_vld,
  output logic [ASZ-1:0] pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ASZ-1:0] COLD_A    = ASZ'(COLD);
  localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);

  fetch_st_t       state_reg, state_next;
  logic [ASZ-3:0]  addr_reg, addr_next;
  logic [ASZ-3:0]  tgt_reg, tgt_next;
  logic [1:0]      off_reg, off_next;
  logic [ASZ-1:0]  pc_reg, pc_next;

  word_t           head_word;
  word_t           cur_word;
  logic            q_full, q_empty;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   occ_next;
  logic            bypass, consume, push, pop;

  ej32_wq #(.DEPTH(DEPTH)) u_wq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (jmp),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (pop),
    .head      (head_word),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

`ifdef EJ32_FETCH_BYPASS_EN
  assign bypass   = q_empty & mem_ack & (state_reg == REQ);
  assign cur_word = bypass ? mem_rdata : head_word;
`else
  assign bypass   = 1'b0;
  assign cur_word = head_word;
`endif

  assign data_vld = ~q_empty | bypass;
  assign data     = data_vld ? byte_lane(cur_word, off_reg) : 8'h00;
  assign mem_req  = (state_reg != IDLE);
  assign mem_addr = addr_reg;
  assign pc       = pc_reg;

  // A bypassed word whose last byte is taken on arrival never needs to enter the queue.
  assign consume  = take & data_vld & ~jmp;
  assign push     = mem_ack & (state_reg == REQ) & ~jmp & ~(bypass & consume & (off_reg == 2'd3));
  assign pop      = consume & ~q_empty & (off_reg == 2'd3);
  assign occ_next = q_count + CW'(push) - CW'(pop);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    tgt_next   = tgt_reg;
    off_next   = off_reg;
    pc_next    = pc_reg;
    if (jmp) begin
      off_next = jmp_addr[1:0];
      pc_next  = jmp_addr;
      // An unanswered request must still complete; park the target until it does.
      if (state_reg != IDLE && !mem_ack) begin
        state_next = DRAIN;
        tgt_next   = jmp_addr[ASZ-1:2];
      end else begin
        state_next = IDLE;
        addr_next  = jmp_addr[ASZ-1:2];
      end
    end else begin
      if (consume) begin
        off_next = off_reg + 2'd1;
        pc_next  = pc_reg + ASZ'(1);
      end
      case (state_reg)
        IDLE: if (!q_full) state_next = REQ;
        REQ: begin
          if (mem_ack) begin
            addr_next = addr_reg + (ASZ - 2)'(1);
            if (occ_next >= DEPTH_CNT) state_next = IDLE;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            addr_next  = tgt_reg;
            state_next = REQ;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= COLD_A[ASZ-1:2];
      tgt_reg   <= COLD_A[ASZ-1:2];
      off_reg   <= COLD_A[1:0];
      pc_reg    <= COLD_A;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      tgt_reg   <= tgt_next;
      off_reg   <= off_next;
      pc_reg    <= pc_next;
    end
  end

endmodule

// File: tb/tb_ej32_fetch.sv
// Self-checking bench for ej32_fetch: directed corner cases plus a randomized run against a byte-stream model.
module tb_ej32_fetch;

`ifdef EJ32_FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        jmp = 1'b0;
  logic [16:0] jmp_addr = '0;
  logic        take = 1'b0;
  logic [7:0]  data;
  logic        data_vld;
  logic [16:0] pc;

  int n_cmp = 0;
  int n_bad = 0;

  ej32_fetch #(.COLD('h100), .ASZ(17), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .take      (take),
    .data      (data),
    .data_vld  (data_vld),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic [16:0] p;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [14:0] a);
    if (a == 15'h40) return 32'h12345678;
    if (a == 15'h41) return 32'h9ABCDEF0;
    return {a[7:0] ^ 8'h5A, a[14:8], 1'b1, ~a[7:0], a[7:0] + 8'h33};
  endfunction

  function automatic logic [7:0] lane(input logic [31:0] w, input int o);
    return 8'((w >> ((3 - o) * 8)) & 32'hFF);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur within its cycle budget", nm);
  endtask

  task automatic drive(input logic t, input logic j, input logic [16:0] ja, input logic ack_en);
    take     = t;
    jmp      = j;
    jmp_addr = ja;
    if (ack_en && mem_req) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_word(mem_addr);
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'h40);
    chk("rst_vld", 32'(data_vld), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_pc", 32'(pc), 32'h100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_vld(input logic t, input string nm, input logic [7:0] ed, input logic [16:0] ep);
    logic got;
    got = 1'b0;
    for (int w = 0; w < 12 && !got; w++) begin
      @(negedge clk);
      drive(t, 1'b0, '0, 1'b1);
      #1;
      if (data_vld) begin
        got = 1'b1;
        chk({nm, "_data"}, 32'(data), 32'(ed));
        chk({nm, "_pc"}, 32'(pc), 32'(ep));
      end
    end
    if (!got) timeout({nm, "_vld"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    logic        got;
    int          n_acks;
    int          n_take;
    int          mq[$];
    int          m_off, m_pc, m_fetch, m_drain_addr, occ, tprob;
    logic        m_req, m_drain, e_vld, byp, ack_now, nreq, r_take, r_jmp;
    logic [16:0] r_ja;
    logic [31:0] cur;

    for (int i = 0; i < 8; i++) begin
      cur       = (i < 4) ? 32'h12345678 : 32'h9ABCDEF0;
      tbl[i].d  = lane(cur, i % 4);
      tbl[i].p  = 17'('h100 + i);
    end

    // Straight-line fetch from the cold address with take held.
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'h40);
    for (int i = 0; i < 8; i++) begin
      wait_vld(1'b1, $sformatf("seq%0d", i), tbl[i].d, tbl[i].p);
    end

    // Queue fills to DEPTH with no consumer, then one word of takes buys one request.
    do_reset();
    n_acks = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, '0, 1'b1);
      #1;
      if (mem_ack) n_acks++;
    end
    chk("fill_reqs", 32'(n_acks), 32'd4);
    chk("full_noreq", 32'(mem_req), 32'd0);
    n_acks = 0;
    n_take = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(n_take < 4, 1'b0, '0, 1'b1);
      #1;
      if (take && data_vld) n_take++;
      if (mem_ack) n_acks++;
    end
    chk("refill_reqs", 32'(n_acks), 32'd1);
    chk("refill_noreq", 32'(mem_req), 32'd0);

    // Redirect into mid-word while a request is outstanding; the late word is discarded.
    do_reset();
    got = 1'b0;
    for (int w = 0; w < 6 && !got; w++) begin
      @(negedge clk);
      if (mem_req) begin
        drive(1'b0, 1'b1, 17'h203, 1'b0);
        got = 1'b1;
      end else begin
        drive(1'b0, 1'b0, '0, 1'b0);
      end
      #1;
    end
    if (!got) timeout("drain_req");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, '0, 1'b0);
      #1;
      chk("drain_vld", 32'(data_vld), 32'd0);
      chk("drain_req", 32'(mem_req), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'h40);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("drain_ack_vld", 32'(data_vld), 32'd0);
    chk("drain_pc", 32'(pc), 32'h203);
    got = 1'b0;
    for (int w = 0; w < 4 && !got; w++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, '0, 1'b0);
      #1;
      if (mem_req) begin
        got = 1'b1;
        chk("tgt_addr", 32'(mem_addr), 32'h80);
      end
    end
    if (!got) timeout("tgt_req");
    wait_vld(1'b1, "tgt0", lane(mem_word(15'h80), 3), 17'h203);
    wait_vld(1'b1, "tgt1", lane(mem_word(15'h81), 0), 17'h204);

    // Redirect coinciding with take and mem_ack.
    do_reset();
    got = 1'b0;
    for (int w = 0; w < 8 && !got; w++) begin
      @(negedge clk);
      if (data_vld && mem_req) begin
        drive(1'b1, 1'b1, 17'h3F1, 1'b1);
        got = 1'b1;
      end else begin
        drive(1'b0, 1'b0, '0, 1'b1);
      end
      #1;
    end
    if (!got) timeout("jta_setup");
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("jta_vld", 32'(data_vld), 32'd0);
    chk("jta_pc", 32'(pc), 32'h3F1);
    chk("jta_req", 32'(mem_req), 32'd0);
    wait_vld(1'b0, "jta", lane(mem_word(15'hFC), 1), 17'h3F1);

    // Asynchronous reset in the middle of a request, stale ack, then first-byte latency.
    do_reset();
    got = 1'b0;
    for (int w = 0; w < 6 && !got; w++) begin
      @(negedge clk);
      if (mem_req) begin
        drive(1'b0, 1'b0, '0, 1'b1);
        got = 1'b1;
      end else begin
        drive(1'b0, 1'b0, '0, 1'b0);
      end
      #1;
    end
    if (!got) timeout("mid_setup");
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("mid_req", 32'(mem_req), 32'd1);
    chk("mid_vld", 32'(data_vld), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_vld", 32'(data_vld), 32'd0);
    chk("arst_pc", 32'(pc), 32'h100);
    chk("arst_addr", 32'(mem_addr), 32'h40);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("stale_vld", 32'(data_vld), 32'd0);
    got = 1'b0;
    for (int w = 0; w < 6 && !got; w++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, '0, 1'b1);
      #1;
      if (mem_ack) begin
        got = 1'b1;
        chk("lat_addr", 32'(mem_addr), 32'h40);
        chk("lat_n_vld", 32'(data_vld), 32'(BYP));
        if (data_vld) chk("lat_n_data", 32'(data), 32'h12);
      end
    end
    if (!got) timeout("lat_ack");
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("lat_n1_vld", 32'(data_vld), 32'd1);
    chk("lat_n1_data", 32'(data), 32'h12);
    chk("lat_n1_pc", 32'(pc), 32'h100);

    // Randomized run against a queue-of-word-addresses model.
    do_reset();
    mq.delete();
    m_off        = 0;
    m_pc         = 'h100;
    m_fetch      = 'h40;
    m_drain_addr = 0;
    m_drain      = 1'b0;
    m_req        = 1'b1;  // the release edge already saw an empty queue
    for (int i = 0; i < 3000; i++) begin
      tprob  = ((i / 400) % 2 == 0) ? 9 : 4;
      r_take = ($urandom_range(0, 9) < tprob);
      r_jmp  = ($urandom_range(0, 39) == 0);
      r_ja   = 17'($urandom_range(0, 'h1FFFF));
      @(negedge clk);
      drive(r_take, r_jmp, r_ja, $urandom_range(0, 2) != 0);
      #1;
      ack_now = mem_ack;
      occ     = mq.size();
      byp     = BYP && ack_now && m_req && !m_drain && (occ == 0);
      e_vld   = (occ != 0) || byp;
      chk("rnd_req", 32'(mem_req), 32'(m_req));
      if (m_req) chk("rnd_addr", 32'(mem_addr), 32'(m_drain ? m_drain_addr : m_fetch));
      chk("rnd_vld", 32'(data_vld), 32'(e_vld));
      chk("rnd_pc", 32'(pc), 32'(m_pc));
      if (e_vld) chk("rnd_data", 32'(data), 32'(lane(mem_word(15'((occ != 0) ? mq[0] : m_fetch)), m_off)));
      if (r_jmp) begin
        nreq = m_req && !ack_now;
        if (nreq && !m_drain) m_drain_addr = m_fetch;
        m_drain = nreq;
        m_req   = nreq;
        mq.delete();
        m_off   = int'(r_ja[1:0]);
        m_pc    = int'(r_ja);
        m_fetch = int'(r_ja) >> 2;
      end else begin
        nreq = m_drain;
        if (m_req && ack_now) begin
          if (m_drain) begin
            m_drain = 1'b0;
          end else begin
            mq.push_back(m_fetch);
            m_fetch = (m_fetch + 1) & 'h7FFF;
          end
        end
        if (r_take && e_vld) begin
          if (m_off == 3) void'(mq.pop_front());
          m_off = (m_off + 1) & 3;
          m_pc  = (m_pc + 1) & 'h1FFFF;
        end
        if (m_req) m_req = (ack_now && !nreq) ? (mq.size() < 4) : 1'b1;
        else       m_req = (occ < 4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
